// File: rtl/phys_reg_free_list_if.sv
// Allocation / release bundle between rename-dispatch-retire and the
// physical register free list.
//
// Signals:
//   alloc_req   [1:0]        per-slot allocation request (bit i = dispatch slot i)
//   alloc_grant              all-or-nothing grant for the current alloc_req
//   alloc_tags  [2*TAG_W-1:0] slot i tag at [i*TAG_W +: TAG_W]
//   free_valid  [1:0]        per-port release strobe
//   free_tags   [2*TAG_W-1:0] port i tag at [i*TAG_W +: TAG_W]
//   free_count  [5:0]        number of tags currently held in the list
//   error                    sticky protocol-error flag
//
// master = rename/retire side, slave = the free list.
interface phys_reg_free_list_if #(
    parameter int TAG_W = 5
);
    logic [1:0]         alloc_req;
    logic               alloc_grant;
    logic [2*TAG_W-1:0] alloc_tags;
    logic [1:0]         free_valid;
    logic [2*TAG_W-1:0] free_tags;
    logic [5:0]         free_count;
    logic               error;

    modport master (
        output alloc_req, free_valid, free_tags,
        input  alloc_grant, alloc_tags, free_count, error
    );

    modport slave (
        input  alloc_req, free_valid, free_tags,
        output alloc_grant, alloc_tags, free_count, error
    );
endinterface

// File: rtl/phys_reg_free_list.sv
// Physical register free list for the out-of-order 6502 core.
// Hands out up to two free physical tags per cycle to rename/dispatch and
// takes back up to two released tags per cycle from retire. Tags 0 and 1 are
// the constant registers and never enter the list.
//
// Ports:
//   clk   sole clock, rising edge
//   rst   asynchronous active-low reset
//   bus   phys_reg_free_list_if.slave (alloc request/grant/tags, release
//         strobes/tags, free_count, sticky error)
module phys_reg_free_list #(
    parameter int TAG_W      = 5,
    parameter int NUM_TAGS   = 32,
    parameter int FIRST_FREE = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    phys_reg_free_list_if.slave     bus
);
    localparam int DEPTH    = NUM_TAGS - 2;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = 6;
    localparam int INIT_CNT = NUM_TAGS - FIRST_FREE;

    logic [TAG_W-1:0]    fifo_q [DEPTH];
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [NUM_TAGS-1:0] in_list_q, in_list_d;
    logic                error_q, error_d;

    logic [1:0]       n_alloc, n_free;
    logic             grant;
    logic [TAG_W-1:0] alloc_tag0, alloc_tag1;
    logic [TAG_W-1:0] free_tag0, free_tag1;
    logic             real0, real1, accept0, accept1, dup0, dup1;
    logic [PTR_W-1:0] wr_ptr1;

    // DEPTH is not a power of two, so pointer wrap is compare-and-subtract.
    function automatic logic [PTR_W-1:0] ptrAdd(input logic [PTR_W-1:0] p,
                                                 input logic [1:0] n);
        logic [PTR_W:0] sum;
        sum = {1'b0, p} + (PTR_W+1)'(n);
        if (sum >= (PTR_W+1)'(DEPTH))
            sum = sum - (PTR_W+1)'(DEPTH);
        return sum[PTR_W-1:0];
    endfunction

    // Allocation: requesting slots are compressed onto consecutive entries
    // starting at head, so a lone slot-1 request takes fifo[head].
    always_comb begin
        n_alloc    = {1'b0, bus.alloc_req[0]} + {1'b0, bus.alloc_req[1]};
        grant      = (count_q >= CNT_W'(n_alloc));
        alloc_tag0 = fifo_q[head_q];
        alloc_tag1 = fifo_q[bus.alloc_req[0] ? ptrAdd(head_q, 2'd1) : head_q];
    end

    // Release: port 0 is handled before port 1, so port 1 repeating port 0's
    // accepted tag counts as a double free.
    always_comb begin
        free_tag0 = bus.free_tags[TAG_W-1:0];
        free_tag1 = bus.free_tags[2*TAG_W-1:TAG_W];
        real0     = bus.free_valid[0] && (free_tag0 > TAG_W'(1));
        real1     = bus.free_valid[1] && (free_tag1 > TAG_W'(1));
        accept0   = real0 && !in_list_q[free_tag0];
        dup0      = real0 &&  in_list_q[free_tag0];
        dup1      = real1 && (in_list_q[free_tag1] || (accept0 && free_tag1 == free_tag0));
        accept1   = real1 && !dup1;
        n_free    = {1'b0, accept0} + {1'b0, accept1};
        wr_ptr1   = accept0 ? ptrAdd(tail_q, 2'd1) : tail_q;
    end

    // Next-state bookkeeping. A granted tag is in the list and an accepted
    // tag is not, so the clear and set below never touch the same bit.
    always_comb begin
        in_list_d = in_list_q;
        if (grant && bus.alloc_req[0]) in_list_d[alloc_tag0] = 1'b0;
        if (grant && bus.alloc_req[1]) in_list_d[alloc_tag1] = 1'b0;
        if (accept0) in_list_d[free_tag0] = 1'b1;
        if (accept1) in_list_d[free_tag1] = 1'b1;
        head_d  = grant ? ptrAdd(head_q, n_alloc) : head_q;
        tail_d  = ptrAdd(tail_q, n_free);
        count_d = count_q - (grant ? CNT_W'(n_alloc) : CNT_W'(0)) + CNT_W'(n_free);
        error_d = error_q | dup0 | dup1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++)
                fifo_q[i] <= (i < INIT_CNT) ? TAG_W'(FIRST_FREE + i) : '0;
            for (int t = 0; t < NUM_TAGS; t++)
                in_list_q[t] <= (t >= FIRST_FREE);
            head_q  <= '0;
            tail_q  <= PTR_W'(INIT_CNT % DEPTH);
            count_q <= CNT_W'(INIT_CNT);
            error_q <= 1'b0;
        end else begin
            if (accept0) fifo_q[tail_q]  <= free_tag0;
            if (accept1) fifo_q[wr_ptr1] <= free_tag1;
            in_list_q <= in_list_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            error_q   <= error_d;
        end
    end

    assign bus.alloc_grant = grant;
    assign bus.alloc_tags  = {alloc_tag1, alloc_tag0};
    assign bus.free_count  = count_q;
    assign bus.error       = error_q;
endmodule
